// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and data-memory wait with timeout.
// Define PIPE_HAZARD_CTRL_PERF_EN to add the stall_cycles / flush_count performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        if_id_flush,
  output logic        id_ex_stall,
  output logic        mem_wb_bubble,
  output logic [1:0]  state,
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count,
`endif
  output logic        mem_timeout
);

  localparam logic [1:0] StRun     = 2'b00;
  localparam logic [1:0] StLuStall = 2'b01;
  localparam logic [1:0] StMemWait = 2'b10;
  localparam logic [1:0] StFlush   = 2'b11;

  localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q, timeout_d;

  logic mem_busy, load_use, lu_eff;
  logic sel_freeze, sel_branch, sel_lu;

  always_comb begin
    mem_busy = mem_req & ~mem_ready & ~timeout_q;
    load_use = ex_memread & (ex_rt != 5'd0) &
               ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    // The instruction behind a taken branch is being flushed, so its hazard is moot.
    lu_eff     = load_use & (state_q != StFlush);
    sel_freeze = ~rst & mem_busy;
    sel_branch = ~rst & ~mem_busy & ex_branch_taken;
    sel_lu     = ~rst & ~mem_busy & ~ex_branch_taken & lu_eff;
  end

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_stall   = 1'b0;
    mem_wb_bubble = 1'b0;
    if (sel_freeze) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (sel_branch) begin
      if_id_flush = 1'b1;
      id_ex_stall = 1'b1;
    end else if (sel_lu) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_stall = 1'b1;
    end
  end

  always_comb begin
    timeout_d  = timeout_q;
    wait_cnt_d = ((state_q == StMemWait) && mem_busy) ? wait_cnt_q + 8'd1 : 8'd0;
    if (mem_busy) begin
      if ((state_q == StMemWait) && (wait_cnt_q == WaitLast)) begin
        timeout_d = 1'b1;
        state_d   = StRun;
      end else begin
        state_d = StMemWait;
      end
    end else if (ex_branch_taken) begin
      state_d = StFlush;
    end else if (lu_eff) begin
      state_d = StLuStall;
    end else begin
      state_d = StRun;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      wait_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign state       = state_q;
  assign mem_timeout = timeout_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [15:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if ((sel_freeze | sel_lu) && (stall_q != '1)) stall_d = stall_q + 32'd1;
    if (sel_branch && (flush_q != '1))            flush_d = flush_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 32'd0;
      flush_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, timeout sequence and
// randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned Tmo = 4;

  localparam logic [6:0] ONorm = 7'b1111000;
  localparam logic [6:0] OFrz  = 7'b0000001;
  localparam logic [6:0] OBr   = 7'b1111110;
  localparam logic [6:0] OLu   = 7'b0011010;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_memread, ex_branch_taken, mem_req, mem_ready;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_stall, mem_wb_bubble;
  logic [1:0] state;
  logic       mem_timeout;
  logic [6:0] outs;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
`endif

  assign outs = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_stall, mem_wb_bubble};

  pipe_hazard_ctrl #(.MEM_TIMEOUT(Tmo)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_memread      (ex_memread),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .id_ex_en        (id_ex_en),
    .ex_mem_en       (ex_mem_en),
    .if_id_flush     (if_id_flush),
    .id_ex_stall     (id_ex_stall),
    .mem_wb_bubble   (mem_wb_bubble),
    .state           (state),
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count),
`endif
    .mem_timeout     (mem_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       r;
    logic [4:0] rs, rt;
    logic       urt, mrd;
    logic [4:0] ert;
    logic       br, mq, my;
    logic [6:0] eo;
    logic [1:0] es;
    logic       et;
  } vec_t;

  function automatic vec_t mk(logic r, logic [4:0] rs, logic [4:0] rt, logic urt, logic mrd,
                              logic [4:0] ert, logic br, logic mq, logic my, logic [6:0] eo,
                              logic [1:0] es, logic et);
    vec_t v;
    v.r = r; v.rs = rs; v.rt = rt; v.urt = urt; v.mrd = mrd; v.ert = ert;
    v.br = br; v.mq = mq; v.my = my; v.eo = eo; v.es = es; v.et = et;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.r; id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.urt; ex_memread = v.mrd;
    ex_rt = v.ert; ex_branch_taken = v.br; mem_req = v.mq; mem_ready = v.my;
  endtask

  // Inputs are applied just after a falling edge; outputs are checked 1 time unit later.
  task automatic step_check(input string name, input logic [6:0] eo, input logic [1:0] es,
                            input logic et);
    #1;
    check({name, ".outs"}, 32'(outs), 32'(eo));
    check({name, ".state"}, 32'(state), 32'(es));
    check({name, ".timeout"}, 32'(mem_timeout), 32'(et));
    @(posedge clk);
    @(negedge clk);
  endtask

  // Behavioural model: tracks state, cycles already spent waiting in MEM_WAIT, the sticky flag.
  int          m_state;
  int          m_waited;
  bit          m_to;
  longint      m_stall;
  int          m_flush;

  function automatic bit m_busy();
    return mem_req && !mem_ready && !m_to;
  endfunction

  function automatic bit m_lu();
    return ex_memread && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt))
           && m_state != 3;
  endfunction

  function automatic logic [6:0] m_out();
    if (rst)             return ONorm;
    if (m_busy())        return OFrz;
    if (ex_branch_taken) return OBr;
    if (m_lu())          return OLu;
    return ONorm;
  endfunction

  task automatic m_step();
    if (rst) begin
      m_state = 0; m_waited = 0; m_to = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (m_busy() || (!ex_branch_taken && m_lu())) begin
        if (m_stall < 64'hFFFF_FFFF) m_stall++;
      end
      if (!m_busy() && ex_branch_taken && m_flush < 65535) m_flush++;
      if (m_busy()) begin
        if (m_state == 2 && m_waited + 1 == Tmo) begin
          m_to = 1; m_state = 0; m_waited = 0;
        end else begin
          m_waited = (m_state == 2) ? m_waited + 1 : 0;
          m_state  = 2;
        end
      end else begin
        m_waited = 0;
        if (ex_branch_taken) m_state = 3;
        else if (m_lu())     m_state = 1;
        else                 m_state = 0;
      end
    end
  endtask

  vec_t tbl[25];

  initial begin
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 1, 1, 0, ONorm, 0, 0);
    tbl[1]  = mk(0, 5, 0, 0, 1, 5, 0, 0, 0, OLu,   0, 0);
    tbl[2]  = mk(0, 5, 0, 0, 0, 5, 0, 0, 0, ONorm, 1, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, ONorm, 0, 0);
    tbl[4]  = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, ONorm, 0, 0);
    tbl[5]  = mk(0, 3, 7, 1, 1, 7, 0, 0, 0, OLu,   0, 0);
    tbl[6]  = mk(0, 3, 7, 0, 1, 7, 0, 0, 0, ONorm, 1, 0);
    tbl[7]  = mk(0, 5, 0, 0, 1, 5, 1, 0, 0, OBr,   0, 0);
    tbl[8]  = mk(0, 5, 0, 0, 1, 5, 0, 0, 0, ONorm, 3, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, ONorm, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, OFrz,  0, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, OFrz,  2, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, OFrz,  2, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, ONorm, 2, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, ONorm, 0, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, OFrz,  0, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, OFrz,  2, 0);
    tbl[17] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, ONorm, 2, 0);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, ONorm, 0, 0);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, OFrz,  0, 0);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, OFrz,  2, 0);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, OBr,   2, 0);
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, ONorm, 3, 0);
    tbl[23] = mk(0, 5, 0, 0, 1, 5, 0, 0, 0, OLu,   0, 0);
    tbl[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, ONorm, 1, 0);

    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, ONorm, 0, 0));
    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i]);
      step_check($sformatf("tbl%0d", i), tbl[i].eo, tbl[i].es, tbl[i].et);
    end

    // Memory never responds: Tmo cycles in MEM_WAIT, then the sticky timeout releases the pipe.
    drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, ONorm, 0, 0));
    for (int k = 0; k <= int'(Tmo); k++)
      step_check($sformatf("tmo_wait%0d", k), OFrz, (k == 0) ? 2'd0 : 2'd2, 1'b0);
    for (int k = 0; k < 3; k++)
      step_check($sformatf("tmo_after%0d", k), ONorm, 2'd0, 1'b1);
    ex_branch_taken = 1'b1;
    step_check("tmo_branch", OBr, 2'd0, 1'b1);
    ex_branch_taken = 1'b0;
    rst = 1'b1;
    step_check("tmo_rst", ONorm, 2'd3, 1'b1);
    rst = 1'b0;
    step_check("tmo_cleared", OFrz, 2'd0, 1'b0);
    mem_ready = 1'b1;
    step_check("tmo_release", ONorm, 2'd2, 1'b0);
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, ONorm, 0, 0));
    @(posedge clk);
    @(negedge clk);

    m_state = 0; m_waited = 0; m_to = 0; m_stall = 0; m_flush = 0;
    for (int n = 0; n < 3000; n++) begin
      rst             = ($urandom_range(0, 99) == 0);
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_rt           = 5'($urandom_range(0, 3));
      id_uses_rt      = 1'($urandom_range(0, 1));
      ex_memread      = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 4) == 0);
      mem_req         = ($urandom_range(0, 9) < 6);
      mem_ready       = ($urandom_range(0, 3) == 0);
      #1;
      check($sformatf("rnd%0d.outs", n), 32'(outs), 32'(m_out()));
      check($sformatf("rnd%0d.state", n), 32'(state), 32'(m_state));
      check($sformatf("rnd%0d.timeout", n), 32'(mem_timeout), 32'(m_to));
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      check($sformatf("rnd%0d.stall_cycles", n), stall_cycles, 32'(m_stall));
      check($sformatf("rnd%0d.flush_count", n), 32'(flush_count), 32'(m_flush));
`endif
      @(posedge clk);
      m_step();
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
